demux_4_buf: RTL and testbench
==============================

Name: demux_4_buf

Overview:
- Buffered 1-to-4 distributor: accepts a {sel, data} word on a valid/ready input and delivers data to exactly one of four destination ports, each with its own valid/ready handshake.
- Sits where a single producer (e.g. ALU/stack-top result path) must feed one of four consumers (register write, stack push, memory write-data, PC load) that may stall independently.
- Internally a small synchronous FIFO of {sel, data}; the head entry is steered to the port named by its sel.

Parameters:
- WIDTH, 32, data width of input and each output.
- DEPTH, 2, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous clear of all buffered entries.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept a word this cycle.
- in_sel  input  2  destination index 0..3.
- in_data  input  WIDTH  payload.
- out_valid  output  4  bit k: head entry targets port k.
- out_ready  input  4  bit k: consumer k accepts.
- out0_data, out1_data, out2_data, out3_data  output  WIDTH each  per-port payload.
- count  output  $clog2(DEPTH)+1  current occupancy.
- busy  output  1  count != 0.

Behaviour:
- Reset: clk is the only clock. rst is synchronous and active-high, sampled on the rising edge of clk. On reset: count=0, read/write pointers=0, in_ready=1 from the next cycle, out_valid=4'b0000, all outN_data=0, busy=0. Storage contents are don't-care.
- Push: in_valid && in_ready at an edge writes {in_sel, in_data} at the write pointer. The pointer wraps modulo DEPTH.
- in_ready = (count != DEPTH), combinational from registered count.
  - No bypass when full: a same-cycle pop does not raise in_ready.
- Pop: out_valid[head_sel] && out_ready[head_sel] at an edge advances the read pointer, with modulo-DEPTH wrap.
- Ready bits on non-selected ports are ignored.
- out_valid = (count != 0) ? onehot(head_sel) : 4'b0000. At most one bit is ever set.
- outK_data = head_data when out_valid[K], else 0.
- Latency: a word accepted at edge N is visible on its port after edge N (first cycle N+1), provided earlier entries have drained. There is no combinational in->out path.
- Ordering: strict FIFO across all destinations. A stalled head blocks later entries for other ports (head-of-line blocking is intended).
- Simultaneous push+pop when 0 < count < DEPTH: count unchanged, both pointers advance.
- count updates: push only → +1; pop only → -1; both → unchanged.
- Handshake stability: once out_valid[k] is asserted, it and outK_data stay constant until the pop, rst or flush.
- flush: takes priority over push/pop in the same cycle. count=0, pointers=0, and the same-cycle input word is discarded even if in_valid && in_ready.
- Priority: rst > flush > push/pop.
- Reset mid-operation: all pending entries are lost and no further out_valid is asserted until a new push.

Decomposition:
- Shared package:
  - destination index constants DEST_REG=2'd0, DEST_STACK=2'd1, DEST_MEM=2'd2, DEST_PC=2'd3.
  - a localparam function for clog2 if the toolflow requires it.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/flush, full/empty/count) stores WIDTH+2-bit entries.
- demux_4_buf contains the FIFO plus the one-hot steering and per-port zeroing logic.

Test Plan:
- Reset release, no traffic → in_ready=1, out_valid=0000, count=0, all outN_data=0 for 10 cycles.
- Push sel=2, data=32'hDEADBEEF, out_ready=4'b0100 → next cycle out_valid=0100 and out2_data=DEADBEEF. Pop on that edge; out_valid=0000 the following cycle.
- Push sel=1 (A=32'h11) then sel=3 (B=32'h33) with out_ready=0000 → count=2, in_ready=0, out_valid=0010 held steady. Raise out_ready[3] only → no pop. Raise out_ready[1] → A delivered, then out_valid=1000 with out3_data=33.
- Full FIFO, out_ready[head] and in_valid both high for one cycle → pop occurs, push does not (in_ready=0). Count goes 2→1 and in_ready=1 on the next cycle.
- Continuous streaming of sel 0,1,2,3,0,… with all out_ready=1 → one delivery per cycle after the first, order preserved, data 1..8 exact. Pointer wrap is exercised.
- count=2 with flush and in_valid asserted the same cycle → next cycle count=0, out_valid=0000, input word not delivered. Repeat with rst mid-stream → same result.

Source files
------------

// File: rtl/demux_4_buf_pkg.sv
// demux_4_buf_pkg: destination indices and one-hot helper shared by the demux and its bench.
package demux_4_buf_pkg;
  localparam logic [1:0] DEST_REG   = 2'd0;
  localparam logic [1:0] DEST_STACK = 2'd1;
  localparam logic [1:0] DEST_MEM   = 2'd2;
  localparam logic [1:0] DEST_PC    = 2'd3;
  function automatic logic [3:0] onehot4(input logic [1:0] s);
    return 4'b0001 << s;
  endfunction
endpackage

// File: rtl/demux_4_buf_if.sv
// demux_4_buf_if: producer handshake, four consumer handshakes and status of the buffered demux.
interface demux_4_buf_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic [WIDTH-1:0] in_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out0_data;
  logic [WIDTH-1:0] out1_data;
  logic [WIDTH-1:0] out2_data;
  logic [WIDTH-1:0] out3_data;
  logic [CW-1:0]    count;
  logic             busy;
  modport master (
    output flush, in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out0_data, out1_data, out2_data, out3_data, count, busy
  );
  modport slave (
    input  flush, in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out0_data, out1_data, out2_data, out3_data, count, busy
  );
endinterface

// File: rtl/demux_4_buf_sync_fifo.sv
// sync_fifo: single-clock FIFO with flush; push ignored when full, pop ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_d  = flush_i ? '0 : wr_q + AW'(do_push);
    rd_d  = flush_i ? '0 : rd_q + AW'(do_pop);
    cnt_d = flush_i ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end
endmodule

// File: rtl/demux_4_buf.sv
// demux_4_buf: buffers {sel, data} words and steers the FIFO head to one of four ports.
module demux_4_buf
  import demux_4_buf_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  demux_4_buf_if.slave   bus
);
  logic [WIDTH+1:0] head;
  logic [1:0]       head_sel;
  logic [WIDTH-1:0] head_data;
  logic             full, empty, pop;
  assign {head_sel, head_data} = head;
  // Only the addressed consumer's ready can retire the head; others are ignored.
  assign pop           = |(bus.out_valid & bus.out_ready);
  assign bus.in_ready  = !full;
  assign bus.busy      = !empty;
  assign bus.out_valid = empty ? 4'b0000 : onehot4(head_sel);
  assign bus.out0_data = bus.out_valid[0] ? head_data : '0;
  assign bus.out1_data = bus.out_valid[1] ? head_data : '0;
  assign bus.out2_data = bus.out_valid[2] ? head_data : '0;
  assign bus.out3_data = bus.out_valid[3] ? head_data : '0;
  sync_fifo #(.WIDTH(WIDTH + 2), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (bus.flush),
    .push_i  (bus.in_valid),
    .pop_i   (pop),
    .wdata_i ({bus.in_sel, bus.in_data}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (bus.count)
  );
endmodule

// File: tb/tb_demux_4_buf.sv
// tb_demux_4_buf: directed and randomized checks of demux_4_buf against a queue model.
module tb_demux_4_buf;
  import demux_4_buf_pkg::*;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [WIDTH+1:0] q[$];
  demux_4_buf_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  demux_4_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    bit do_pop, do_push;
    logic [WIDTH+1:0] w;
    do_pop  = q.size() > 0 && bus.out_ready[q[0][WIDTH+1:WIDTH]];
    do_push = bus.in_valid && q.size() < DEPTH;
    w = {bus.in_sel, bus.in_data};
    @(posedge clk);
    if (rst || bus.flush) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(w);
    end
    #1;
  endtask

  task automatic idle();
    bus.flush = 0; bus.in_valid = 0; bus.in_sel = 0; bus.in_data = 0; bus.out_ready = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1; tick(); tick(); rst = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if ({bus.in_ready, bus.out_valid, bus.count, bus.busy} !== {1'b1, 4'b0, 2'd0, 1'b0}) begin
        fails++; $display("FAIL reset_status got rdy=%b v=%b cnt=%0d busy=%b exp 1 0000 0 0", bus.in_ready, bus.out_valid, bus.count, bus.busy);
      end
      tests++;
      if ((bus.out0_data | bus.out1_data | bus.out2_data | bus.out3_data) !== '0) begin
        fails++; $display("FAIL reset_data got %h %h %h %h exp all 0", bus.out0_data, bus.out1_data, bus.out2_data, bus.out3_data);
      end
    end
  endtask

  task automatic test_single();
    idle(); bus.in_valid = 1; bus.in_sel = DEST_MEM; bus.in_data = 32'hDEADBEEF; bus.out_ready = 4'b0100;
    tick(); bus.in_valid = 0;
    tests++;
    if (bus.out_valid !== 4'b0100 || bus.out2_data !== 32'hDEADBEEF) begin
      fails++; $display("FAIL single_deliver got v=%b d=%h exp 0100 deadbeef", bus.out_valid, bus.out2_data);
    end
    tests++;
    if ((bus.out0_data | bus.out1_data | bus.out3_data) !== '0) begin
      fails++; $display("FAIL single_zero got %h %h %h exp 0", bus.out0_data, bus.out1_data, bus.out3_data);
    end
    tick();
    tests++;
    if (bus.out_valid !== 4'b0000 || bus.count !== 2'd0) begin
      fails++; $display("FAIL single_pop got v=%b cnt=%0d exp 0000 0", bus.out_valid, bus.count);
    end
  endtask

  task automatic test_hol();
    idle(); bus.in_valid = 1; bus.in_sel = DEST_STACK; bus.in_data = 32'h11;
    tick(); bus.in_sel = DEST_PC; bus.in_data = 32'h33;
    tick(); bus.in_valid = 0;
    tests++;
    if (bus.count !== 2'd2 || bus.in_ready !== 1'b0 || bus.out_valid !== 4'b0010 || bus.out1_data !== 32'h11) begin
      fail_hol("hol_full", 2'd2, 4'b0010);
    end
    bus.out_ready = 4'b1000;
    tick(); tick();
    tests++;
    if (bus.count !== 2'd2 || bus.out_valid !== 4'b0010 || bus.out1_data !== 32'h11) begin
      fail_hol("hol_blocked", 2'd2, 4'b0010);
    end
    bus.out_ready = 4'b0010;
    tick();
    tests++;
    if (bus.count !== 2'd1 || bus.out_valid !== 4'b1000 || bus.out3_data !== 32'h33) begin
      fails++; $display("FAIL hol_second got cnt=%0d v=%b d3=%h exp 1 1000 33", bus.count, bus.out_valid, bus.out3_data);
    end
    bus.out_ready = 4'b1000;
    tick();
    tests++;
    if (bus.count !== 2'd0 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL hol_drain got cnt=%0d busy=%b exp 0 0", bus.count, bus.busy);
    end
  endtask

  task automatic fail_hol(input string name, input logic [1:0] c, input logic [3:0] v);
    fails++;
    $display("FAIL %s got cnt=%0d rdy=%b v=%b d1=%h exp cnt=%0d rdy=0 v=%b d1=11", name, bus.count, bus.in_ready, bus.out_valid, bus.out1_data, c, v);
  endtask

  task automatic test_full_pop();
    idle(); bus.in_valid = 1; bus.in_sel = DEST_REG; bus.in_data = 32'h5;
    tick(); bus.in_sel = DEST_STACK; bus.in_data = 32'h6;
    tick(); bus.in_sel = DEST_MEM; bus.in_data = 32'h7; bus.out_ready = 4'b0001;
    tick(); bus.in_valid = 0; bus.out_ready = 0;
    tests++;
    if (bus.count !== 2'd1 || bus.in_ready !== 1'b1 || bus.out_valid !== 4'b0010 || bus.out1_data !== 32'h6) begin
      fails++; $display("FAIL full_pop got cnt=%0d rdy=%b v=%b d1=%h exp 1 1 0010 6", bus.count, bus.in_ready, bus.out_valid, bus.out1_data);
    end
    bus.out_ready = 4'b1111;
    tick();
    tests++;
    if (bus.count !== 2'd0 || bus.out_valid !== 4'b0000) begin
      fails++; $display("FAIL full_nopush got cnt=%0d v=%b exp 0 0000", bus.count, bus.out_valid);
    end
  endtask

  task automatic test_stream();
    idle(); bus.out_ready = 4'b1111; bus.in_valid = 1;
    for (int i = 1; i <= 8; i++) begin
      logic [WIDTH-1:0] got [4];
      logic [1:0] s;
      s = 2'((i - 1) % 4);
      bus.in_sel = s; bus.in_data = i;
      tick();
      got = '{bus.out0_data, bus.out1_data, bus.out2_data, bus.out3_data};
      tests++;
      if (bus.out_valid !== onehot4(s) || got[s] !== WIDTH'(i) || bus.count !== 2'd1) begin
        fails++; $display("FAIL stream_%0d got v=%b d=%h cnt=%0d exp v=%b d=%0h cnt=1", i, bus.out_valid, got[s], bus.count, onehot4(s), i);
      end
    end
    bus.in_valid = 0;
    tick();
    tests++;
    if (bus.count !== 2'd0) begin
      fails++; $display("FAIL stream_end got cnt=%0d exp 0", bus.count);
    end
  endtask

  task automatic test_clear(input bit use_rst);
    idle(); bus.in_valid = 1; bus.in_sel = DEST_REG; bus.in_data = 32'hA;
    tick(); bus.in_data = 32'hB;
    tick(); bus.in_data = 32'h99;
    if (use_rst) rst = 1; else bus.flush = 1;
    tick(); rst = 0; bus.flush = 0; bus.in_valid = 0; bus.out_ready = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (bus.count !== 2'd0 || bus.out_valid !== 4'b0000 || bus.out0_data !== '0) begin
        fails++; $display("FAIL clear_%s_%0d got cnt=%0d v=%b d0=%h exp 0 0000 0", use_rst ? "rst" : "flush", i, bus.count, bus.out_valid, bus.out0_data);
      end
      tick();
    end
  endtask

  task automatic test_random();
    idle();
    for (int n = 0; n < 400; n++) begin
      logic [WIDTH-1:0] got [4];
      logic [3:0] ev;
      logic [WIDTH-1:0] ed;
      bus.in_valid  = $urandom_range(0, 1);
      bus.in_sel    = 2'($urandom);
      bus.in_data   = $urandom;
      bus.out_ready = 4'($urandom);
      bus.flush     = $urandom_range(0, 31) == 0;
      rst           = $urandom_range(0, 63) == 0;
      tick();
      ev = q.size() > 0 ? onehot4(q[0][WIDTH+1:WIDTH]) : 4'b0000;
      ed = q.size() > 0 ? q[0][WIDTH-1:0] : '0;
      got = '{bus.out0_data, bus.out1_data, bus.out2_data, bus.out3_data};
      tests++;
      if (bus.out_valid !== ev || bus.count !== 2'(q.size()) || bus.in_ready !== (q.size() < DEPTH) || bus.busy !== (q.size() != 0)) begin
        fails++; $display("FAIL rand_status_%0d got v=%b cnt=%0d rdy=%b busy=%b exp v=%b cnt=%0d", n, bus.out_valid, bus.count, bus.in_ready, bus.busy, ev, q.size());
      end
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (got[k] !== (ev[k] ? ed : '0)) begin
          fails++; $display("FAIL rand_data_%0d_p%0d got %h exp %h", n, k, got[k], ev[k] ? ed : '0);
        end
      end
    end
    rst = 0; idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_hol();
    test_full_pop();
    test_stream();
    test_clear(0);
    test_clear(1);
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
